// File: rtl/verdict_collector.sv
// verdict_collector: gathers per-stream monitor verdict updates into an ordered FWFT record FIFO.
// Optional macro COLLECTOR_TS_EN adds a free-running timestamp, per-slot/FIFO ts storage and out_ts.
module verdict_collector #(
  parameter int N_STREAMS  = 12,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int TS_W       = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [N_STREAMS*DATA_W-1:0]   res_data,
  input  logic [N_STREAMS-1:0]          res_upd,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [3:0]                    out_id,
  output logic [DATA_W-1:0]             out_data,
`ifdef COLLECTOR_TS_EN
  output logic [TS_W-1:0]               out_ts,
`endif
  output logic [15:0]                   overrun_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [N_STREAMS-1:0] pending_q, pending_d;
  logic [N_STREAMS-1:0] upd, sel_oh, ovr;
  logic [DATA_W-1:0]    slot_data_q [N_STREAMS];
  logic [3:0]           fifo_id_q   [FIFO_DEPTH];
  logic [DATA_W-1:0]    fifo_data_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic [15:0]          ovr_cnt_q, ovr_cnt_d;
  logic [4:0]           n_ovr;
  logic [16:0]          ovr_sum;
  logic [3:0]           sel_idx;
  logic                 full, push, pop;
`ifdef COLLECTOR_TS_EN
  logic [TS_W-1:0]      ts_q, ts_d;
  logic [TS_W-1:0]      slot_ts_q [N_STREAMS];
  logic [TS_W-1:0]      fifo_ts_q [FIFO_DEPTH];
`endif

  // Pick the lowest pending stream; full is judged on the registered level only, so a pop never frees space in the same cycle.
  always_comb begin
    upd     = en ? res_upd : '0;
    full    = level_q == LW'(FIFO_DEPTH);
    sel_oh  = full ? '0 : pending_q & (~pending_q + 1'b1);
    push    = |sel_oh;
    pop     = out_valid && out_ready;
    sel_idx = '0;
    for (int i = N_STREAMS - 1; i >= 0; i--)
      if (pending_q[i]) sel_idx = 4'(i);
  end

  // A strobe on a stream that is pending and not being drained this cycle loses the older value and counts as an overrun.
  always_comb begin
    ovr       = upd & pending_q & ~sel_oh;
    pending_d = upd | (pending_q & ~sel_oh);
    n_ovr     = '0;
    for (int i = 0; i < N_STREAMS; i++)
      n_ovr = n_ovr + {4'd0, ovr[i]};
    ovr_sum   = {1'b0, ovr_cnt_q} + {12'd0, n_ovr};
    ovr_cnt_d = ovr_sum[16] ? 16'hFFFF : ovr_sum[15:0];
    wr_ptr_d  = wr_ptr_q + AW'(push);
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    level_d   = level_q + LW'(push) - LW'(pop);
`ifdef COLLECTOR_TS_EN
    ts_d      = ts_q + TS_W'(en);
`endif
  end

  // Control state; reset drops everything queued or pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovr_cnt_q <= '0;
`ifdef COLLECTOR_TS_EN
      ts_q      <= '0;
`endif
    end else begin
      pending_q <= pending_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovr_cnt_q <= ovr_cnt_d;
`ifdef COLLECTOR_TS_EN
      ts_q      <= ts_d;
`endif
    end
  end

  // Slot and FIFO payload storage; the slot is read before being overwritten so a same-cycle select pushes the old value.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_STREAMS; i++)
      if (upd[i]) slot_data_q[i] <= res_data[i*DATA_W +: DATA_W];
    if (push) begin
      fifo_id_q[wr_ptr_q]   <= sel_idx;
      fifo_data_q[wr_ptr_q] <= slot_data_q[sel_idx];
    end
`ifdef COLLECTOR_TS_EN
    for (int i = 0; i < N_STREAMS; i++)
      if (upd[i]) slot_ts_q[i] <= ts_q;
    if (push) fifo_ts_q[wr_ptr_q] <= slot_ts_q[sel_idx];
`endif
  end

  // First-word-fall-through head, forced to zero while empty.
  always_comb begin
    out_valid   = level_q != '0;
    out_id      = out_valid ? fifo_id_q[rd_ptr_q] : '0;
    out_data    = out_valid ? fifo_data_q[rd_ptr_q] : '0;
`ifdef COLLECTOR_TS_EN
    out_ts      = out_valid ? fifo_ts_q[rd_ptr_q] : '0;
`endif
    overrun_cnt = ovr_cnt_q;
    fifo_level  = level_q;
  end
endmodule

// File: tb/tb_verdict_collector.sv
// tb_verdict_collector: directed stimulus with an expected-record queue checked by an independent output monitor.
module tb_verdict_collector;
  localparam int N = 12;
  localparam int DW = 32;
  localparam int TW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            en = 1'b1;
  logic [N*DW-1:0] res_data = '0;
  logic [N-1:0]    res_upd = '0;
  logic            out_valid, out_ready = 1'b0;
  logic [3:0]      out_id;
  logic [DW-1:0]   out_data;
  logic [TW-1:0]   out_ts;
  logic [15:0]     overrun_cnt;
  logic [4:0]      fifo_level;

  typedef struct {logic [3:0] id; logic [DW-1:0] data; logic [TW-1:0] ts;} rec_t;
  rec_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int tsm = 0;
  logic          hold_v = 1'b0;
  logic [3:0]    hold_id;
  logic [DW-1:0] hold_data;

  verdict_collector dut (
    .clk(clk), .rst(rst), .en(en), .res_data(res_data), .res_upd(res_upd),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_data(out_data),
`ifdef COLLECTOR_TS_EN
    .out_ts(out_ts),
`endif
    .overrun_cnt(overrun_cnt), .fifo_level(fifo_level)
  );
`ifndef COLLECTOR_TS_EN
  assign out_ts = '0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: compares every accepted record with the queue head and checks the head holds steady while stalled.
  always @(negedge clk) begin
    if (!rst) hold_v = 1'b0;
    else begin
      if (hold_v) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_id", 64'(out_id), 64'(hold_id));
        chk("stall_data", 64'(out_data), 64'(hold_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_record_id", 64'(out_id), 64'hFFFF);
        else begin
          rec_t r;
          r = exp_q.pop_front();
          chk("rec_id", 64'(out_id), 64'(r.id));
          chk("rec_data", 64'(out_data), 64'(r.data));
`ifdef COLLECTOR_TS_EN
          chk("rec_ts", 64'(out_ts), 64'(r.ts));
`endif
        end
      end
      hold_v = out_valid && !out_ready;
      hold_id = out_id;
      hold_data = out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    tsm = !rst ? 0 : tsm + (en ? 1 : 0);
    #1;
  endtask

  task automatic strobe(input int idx, input logic [DW-1:0] v, input logic queued);
    rec_t r;
    res_data[idx*DW +: DW] = v;
    res_upd[idx] = 1'b1;
    r.id = 4'(idx); r.data = v; r.ts = TW'(tsm);
    if (queued) exp_q.push_back(r);
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin tick(); n++; end
    if (n >= 200) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    tick(); tick();
    chk("drained_level", 64'(fifo_level), 64'd0);
    chk("drained_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_level", 64'(fifo_level), 64'd0);
    chk("reset_overrun", 64'(overrun_cnt), 64'd0);
    chk("reset_id", 64'(out_id), 64'd0);
    chk("reset_data", 64'(out_data), 64'd0);
    rst = 1'b1;
    repeat (5) tick();
    // Single strobe at ts 5, visible two cycles later.
    strobe(0, 32'd7, 1'b0);
    exp_q.push_back('{id: 4'd0, data: 32'd7, ts: 32'd5});
    tick(); res_upd = '0;
    chk("lat_t1_valid", 64'(out_valid), 64'd0);
    tick();
    chk("lat_t2_valid", 64'(out_valid), 64'd1);
    chk("lat_t2_level", 64'(fifo_level), 64'd1);
    drain();
    // Two streams in one cycle leave in index order.
    strobe(2, 32'd2, 1'b0); strobe(1, 32'd1, 1'b1);
    exp_q.push_back('{id: 4'd2, data: 32'd2, ts: TW'(tsm)});
    tick(); res_upd = '0;
    drain();
    chk("pair_overrun", 64'(overrun_cnt), 64'd0);
    // Seventeen back-to-back updates on stream 3: sixteen fill the FIFO, the last waits pending.
    out_ready = 1'b0;
    for (int k = 1; k <= 17; k++) begin strobe(3, DW'(k), 1'b1); tick(); end
    res_upd = '0; tick();
    chk("fill_level", 64'(fifo_level), 64'd16);
    tick();
    chk("full_hold_level", 64'(fifo_level), 64'd16);
    drain();
    chk("fill_overrun", 64'(overrun_cnt), 64'd0);
    // Full FIFO, then 8 and 9 on stream 4: 8 is overwritten.
    out_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin strobe(4, DW'(100 + k), 1'b1); tick(); end
    res_upd = '0; tick();
    chk("full2_level", 64'(fifo_level), 64'd16);
    strobe(4, 32'd8, 1'b0); tick();
    strobe(4, 32'd9, 1'b1); tick(); res_upd = '0;
    chk("overrun_one", 64'(overrun_cnt), 64'd1);
    drain();
    chk("overrun_after_drain", 64'(overrun_cnt), 64'd1);
    // Reset mid-drain discards everything.
    out_ready = 1'b0;
    strobe(5, 32'd50, 1'b1); strobe(6, 32'd60, 1'b1);
    tick(); res_upd = '0; tick(); tick();
    chk("pre_reset_level", 64'(fifo_level), 64'd2);
    out_ready = 1'b1;
    tick();
    rst = 1'b0; exp_q.delete(); tsm = 0;
    #1;
    chk("midreset_valid", 64'(out_valid), 64'd0);
    chk("midreset_level", 64'(fifo_level), 64'd0);
    chk("midreset_overrun", 64'(overrun_cnt), 64'd0);
    tick();
    rst = 1'b1;
    strobe(2, 32'd55, 1'b0);
    exp_q.push_back('{id: 4'd2, data: 32'd55, ts: 32'd0});
    tick(); res_upd = '0;
    // Disabled: strobes ignored and timestamp frozen at 1, draining continues.
    en = 1'b0; res_upd = '1;
    repeat (4) tick();
    res_upd = '0; en = 1'b1;
    chk("en0_level", 64'(fifo_level), 64'd0);
    chk("en0_overrun", 64'(overrun_cnt), 64'd0);
    strobe(6, 32'd66, 1'b0);
    exp_q.push_back('{id: 4'd6, data: 32'd66, ts: 32'd1});
    tick(); res_upd = '0;
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
